// File: rtl/ps2_key_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_key_pkg                                                                |
// | Shared constants for the PS/2 set-2 key decoder: prefix bytes, decoder     |
// | FSM state encoding and the default key-table index names.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ps2_key_pkg;

  // Set-2 prefix bytes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Decoder FSM state encoding
  typedef logic [1:0] ps2_state_t;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // Index of each key in the default table
  localparam int KEY_ESC   = 0;
  localparam int KEY_ENTER = 1;
  localparam int KEY_S     = 2;
  localparam int KEY_A     = 3;
  localparam int KEY_KP5   = 4;
  localparam int KEY_KP4   = 5;

  // Largest of three values, used to size the shared counter width
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_repeat_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_repeat_timer                                                           |
// | Auto-repeat timer: after a load it ticks once DELAY cycles later, then     |
// | every PERIOD cycles until stopped or reloaded.                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_repeat_timer #(
  parameter int DELAY  = 1,
  parameter int PERIOD = 1,
  parameter int CW     = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic stop,
  output logic tick
);

  localparam logic [CW-1:0] DLY = CW'(DELAY);
  localparam logic [CW-1:0] PER = CW'(PERIOD);

  logic          active;
  logic          in_period;
  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;

  // The counter runs 1..limit, so it never exceeds its terminal value
  assign limit = in_period ? PER : DLY;
  assign tick  = active && (cnt == limit);

  // Load restarts the delay phase; each tick reloads into the period phase
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active    <= 1'b0;
      in_period <= 1'b0;
      cnt       <= '0;
    end else if (load) begin
      active    <= 1'b1;
      in_period <= 1'b0;
      cnt       <= CW'(1);
    end else if (stop) begin
      active    <= 1'b0;
      in_period <= 1'b0;
      cnt       <= '0;
    end else if (active) begin
      if (tick) begin
        in_period <= 1'b1;
        cnt       <= CW'(1);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_key_decoder                                                            |
// | Decodes PS/2 set-2 make/break/E0 sequences against a key table and emits   |
// | per-key press/release pulses, held levels and optional auto-repeat.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int                    NUM_KEYS      = 6,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES     = {9'h06B, 9'h073, 9'h01C, 9'h01B, 9'h05A, 9'h076},
  parameter int                    TIMEOUT       = 50000,
  parameter int                    REPEAT_DELAY  = 0,
  parameter int                    REPEAT_PERIOD = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [7:0]          scan_code,
  input  logic                scan_valid,
  input  logic                flush,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                unknown_code
);

  localparam int              CW       = $clog2(max3(TIMEOUT, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam int              IW       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);

  ps2_state_t          state;
  ps2_state_t          state_nxt;
  logic [CW-1:0]       tmo_cnt;
  logic                tmo_expire;
  logic                seq_done;
  logic                seq_ext;
  logic                seq_brk;
  logic [NUM_KEYS-1:0] match_oh;
  logic                hit;
  logic [IW-1:0]       hit_idx;
  logic                make_new;
  logic                brk_held;
  logic                unknown_nxt;
  logic                rel_rep;
  logic [IW-1:0]       rep_key;
  logic                rep_tick;
  logic                rep_fire;
  logic [NUM_KEYS-1:0] press_nxt;

  // A pending prefix is abandoned on the TIMEOUT-th idle cycle; a byte in that cycle wins
  assign tmo_expire = (state != ST_IDLE) && !scan_valid && (tmo_cnt == TMO_LAST);

  // Sequence tracking: next state and whether this byte completes a make/break
  always_comb begin
    state_nxt = state;
    seq_done  = 1'b0;
    seq_ext   = 1'b0;
    seq_brk   = 1'b0;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == PS2_EXT)        state_nxt = ST_EXT;
          else if (scan_code == PS2_BREAK) state_nxt = ST_BRK;
          else if (scan_code != PS2_PAUSE) seq_done  = 1'b1;
        end
        ST_EXT: begin
          if (scan_code == PS2_BREAK) begin
            state_nxt = ST_EXT_BRK;
          end else begin
            state_nxt = ST_IDLE;
            seq_done  = 1'b1;
            seq_ext   = 1'b1;
          end
        end
        ST_BRK: begin
          state_nxt = ST_IDLE;
          seq_done  = 1'b1;
          seq_brk   = 1'b1;
        end
        default: begin
          state_nxt = ST_IDLE;
          seq_done  = 1'b1;
          seq_ext   = 1'b1;
          seq_brk   = 1'b1;
        end
      endcase
    end else if (tmo_expire) begin
      state_nxt = ST_IDLE;
    end
  end

  // Table lookup; the lowest matching index wins when entries are duplicated
  always_comb begin
    match_oh = '0;
    hit      = 1'b0;
    hit_idx  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!hit && (KEY_CODES[9*i +: 9] == {seq_ext, scan_code})) begin
        match_oh[i] = 1'b1;
        hit         = 1'b1;
        hit_idx     = IW'(i);
      end
    end
  end

  // Key events; flush suppresses everything in its cycle
  assign make_new    = seq_done && !seq_brk && hit && |(match_oh & ~key_held) && !flush;
  assign brk_held    = seq_done &&  seq_brk && hit && |(match_oh &  key_held) && !flush;
  assign unknown_nxt = seq_done && !hit && !flush;
  assign rel_rep     = brk_held && (hit_idx == rep_key);

  // A repeat tick yields to a new make and to the release of the repeating key
  assign rep_fire = rep_tick && key_held[rep_key] && !flush && !make_new && !rel_rep;

  // Press pulses from a new make or from an auto-repeat tick
  always_comb begin
    press_nxt = make_new ? match_oh : '0;
    if (rep_fire) press_nxt[rep_key] = 1'b1;
  end

  generate
    if (REPEAT_DELAY > 0) begin : g_repeat
      ps2_repeat_timer #(
        .DELAY  (REPEAT_DELAY),
        .PERIOD (REPEAT_PERIOD),
        .CW     (CW)
      ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .load   (make_new),
        .stop   (flush || rel_rep),
        .tick   (rep_tick)
      );
    end else begin : g_no_repeat
      assign rep_tick = 1'b0;
    end
  endgenerate

  // Decoder state and prefix timeout counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= flush ? ST_IDLE : state_nxt;
      if (flush || scan_valid || tmo_expire || (state == ST_IDLE)) tmo_cnt <= '0;
      else                                                       tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Registered key outputs, held levels and the key owned by the repeat timer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_press    <= '0;
      key_release  <= '0;
      key_held     <= '0;
      unknown_code <= 1'b0;
      rep_key      <= '0;
    end else begin
      key_press    <= press_nxt;
      key_release  <= brk_held ? match_oh : '0;
      unknown_code <= unknown_nxt;
      if (flush)         key_held <= '0;
      else if (make_new) key_held <= key_held | match_oh;
      else if (brk_held) key_held <= key_held & ~match_oh;
      if (make_new) rep_key <= hit_idx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ps2_key_decoder                                                         |
// | Self-checking bench: directed sequences plus random byte traffic compared  |
// | cycle by cycle against a sequence-level reference model.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ps2_key_decoder;
  import ps2_key_pkg::*;

  localparam int            NK      = 6;
  localparam logic [9*NK-1:0] CODES = {9'h06B, 9'h073, 9'h01C, 9'h01B, 9'h05A, 9'h076};
  localparam int            TMO     = 50000;
  localparam int            RD      = 10;
  localparam int            RP      = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    scan_code = 8'h00;
  logic          scan_valid = 1'b0;
  logic          flush = 1'b0;
  logic [NK-1:0] key_press, key_release, key_held;
  logic          unknown_code;

  ps2_key_decoder #(
    .NUM_KEYS      (NK),
    .KEY_CODES     (CODES),
    .TIMEOUT       (TMO),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .scan_code    (scan_code),
    .scan_valid   (scan_valid),
    .flush        (flush),
    .key_press    (key_press),
    .key_release  (key_release),
    .key_held     (key_held),
    .unknown_code (unknown_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (sequence level, absolute cycle times) ----
  logic [9*NK-1:0] tbl;
  assign tbl = CODES;

  logic [NK-1:0] m_held = '0, exp_press = '0, exp_rel = '0, exp_held = '0;
  logic          exp_unk = 1'b0;
  bit            m_ext, m_brk, rep_on, tick, done, isbrk, ise, newp;
  longint        cyc = 0, m_last = 0, next_rep = 0;
  int            rep_key, idx;

  function automatic int lookup(input bit e, input logic [7:0] c);
    for (int i = 0; i < NK; i++)
      if (tbl[9*i +: 9] == {e, c}) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    exp_press = '0; exp_rel = '0; exp_unk = 1'b0;
    if (!resetn || flush) begin
      m_held = '0; m_ext = 0; m_brk = 0; rep_on = 0;
    end else begin
      tick = rep_on && (cyc == next_rep);
      done = 0; newp = 0; isbrk = 0; ise = 0;
      if ((m_ext || m_brk) && !scan_valid && (cyc - m_last >= TMO)) begin
        m_ext = 0; m_brk = 0;
      end
      if (scan_valid) begin
        if (m_brk) begin
          done = 1; isbrk = 1; ise = m_ext; m_ext = 0; m_brk = 0;
        end else if (m_ext) begin
          if (scan_code == 8'hF0) begin m_brk = 1; m_last = cyc; end
          else begin done = 1; ise = 1; m_ext = 0; end
        end else if (scan_code == 8'hE0) begin
          m_ext = 1; m_last = cyc;
        end else if (scan_code == 8'hF0) begin
          m_brk = 1; m_last = cyc;
        end else if (scan_code != 8'hE1) begin
          done = 1;
        end
      end
      if (done) begin
        idx = lookup(ise, scan_code);
        if (idx < 0) exp_unk = 1'b1;
        else if (!isbrk && !m_held[idx]) begin
          m_held[idx] = 1'b1; exp_press[idx] = 1'b1; newp = 1;
          rep_on = 1; rep_key = idx; next_rep = cyc + RD;
        end else if (isbrk && m_held[idx]) begin
          m_held[idx] = 1'b0; exp_rel[idx] = 1'b1;
          if (rep_on && rep_key == idx) begin rep_on = 0; tick = 0; end
        end
      end
      if (tick && !newp) begin
        exp_press[rep_key] = 1'b1; next_rep = cyc + RP;
      end
    end
    exp_held = m_held;
  end

  // ---------------- per-cycle comparison and pulse counters -------------------
  bit chk_en = 0;
  int pc[NK];
  int tot_press = 0, tot_rel = 0, tot_unk = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("press",   32'(key_press),    32'(exp_press));
      check_val("release", 32'(key_release),  32'(exp_rel));
      check_val("held",    32'(key_held),     32'(exp_held));
      check_val("unknown", 32'(unknown_code), 32'(exp_unk));
    end
    if (resetn) begin
      for (int i = 0; i < NK; i++) begin
        pc[i]     += int'(key_press[i]);
        tot_press += int'(key_press[i]);
        tot_rel   += int'(key_release[i]);
      end
      tot_unk += int'(unknown_code);
    end
  end

  // ---------------- stimulus helpers ------------------------------------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit fl = 1'b0);
    scan_code = b; scan_valid = 1'b1; flush = fl;
    @(posedge clk); #2;
    scan_valid = 1'b0; flush = 1'b0; scan_code = 8'($urandom);
    idle(gap);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int          p0, r0, u0, t0;
  logic [31:0] seen;
  logic [7:0]  b;
  int          r, gap, k;

  initial begin
    for (int i = 0; i < NK; i++) pc[i] = 0;
    repeat (3) @(posedge clk); #2;
    check_val("rst_press",   32'(key_press),    0);
    check_val("rst_release", 32'(key_release),  0);
    check_val("rst_held",    32'(key_held),     0);
    check_val("rst_unknown", 32'(unknown_code), 0);
    resetn = 1'b1; chk_en = 1;
    idle(2);

    // Make then break of A
    send(8'h1C, 0);
    check_val("a_press", 32'(key_press[KEY_A]), 1);
    check_val("a_held",  32'(key_held[KEY_A]), 1);
    idle(3);
    check_val("a_held_lvl", 32'(key_held[KEY_A]), 1);
    send(PS2_BREAK, 1);
    send(8'h1C, 0);
    check_val("a_release",  32'(key_release[KEY_A]), 1);
    check_val("a_held_off", 32'(key_held[KEY_A]), 0);
    idle(2);

    // Extended 6B is not in the table
    u0 = tot_unk;
    send(PS2_EXT, 1);
    send(8'h6B, 3);
    check_val("ext_unknown_cnt", 32'(tot_unk - u0), 1);
    check_val("ext_no_hold", 32'(key_held[KEY_KP4]), 0);

    // Plain 6B plus three typematic repeats -> one press
    p0 = pc[KEY_KP4];
    send(8'h6B, 1); send(8'h6B, 1); send(8'h6B, 1); send(8'h6B, 1);
    check_val("kp4_press_once", 32'(pc[KEY_KP4] - p0), 1);
    r0 = tot_rel;
    send(PS2_BREAK, 0); send(8'h6B, 2);
    check_val("kp4_release", 32'(tot_rel - r0), 1);

    // Auto-repeat on Enter: pulses at +1, +11, +15, +19
    send(8'h5A, 0);
    seen = '0;
    if (key_press[KEY_ENTER]) seen[1] = 1'b1;
    for (int j = 2; j <= 20; j++) begin
      idle(1);
      if (key_press[KEY_ENTER]) seen[j] = 1'b1;
    end
    check_val("rep_pattern", seen, 32'h0008_8802);
    send(PS2_BREAK, 0); send(8'h5A, 0);
    p0 = pc[KEY_ENTER];
    idle(30);
    check_val("rep_stopped", 32'(pc[KEY_ENTER] - p0), 0);

    // Break of a key that is not held
    t0 = tot_press + tot_rel + tot_unk;
    send(PS2_BREAK, 1); send(8'h73, 3);
    check_val("kp5_quiet", 32'(tot_press + tot_rel + tot_unk - t0), 0);

    // Reset in the middle of E0 F0
    send(8'h1C, 2);
    send(PS2_EXT, 0); send(PS2_BREAK, 0);
    resetn = 1'b0; chk_en = 0;
    #1;
    check_val("mid_rst_press", 32'(key_press), 0);
    check_val("mid_rst_held",  32'(key_held),  0);
    check_val("mid_rst_rel",   32'(key_release), 0);
    check_val("mid_rst_unk",   32'(unknown_code), 0);
    idle(2);
    resetn = 1'b1; chk_en = 1;
    send(8'h1B, 0);
    check_val("s_after_rst", 32'(key_press[KEY_S]), 1);
    check_val("s_after_rst_unk", 32'(unknown_code), 0);
    send(PS2_BREAK, 0); send(8'h1B, 2);

    // Flush releases held keys silently
    send(8'h1B, 1); send(8'h1C, 1);
    r0 = tot_rel;
    flush = 1'b1; idle(1); flush = 1'b0;
    check_val("flush_held", 32'(key_held), 0);
    idle(2);
    check_val("flush_norel", 32'(tot_rel - r0), 0);
    send(8'h1B, 0);
    check_val("s_after_flush", 32'(key_press[KEY_S]), 1);
    send(PS2_BREAK, 0); send(8'h1B, 2);

    // Prefix timeout: E0 then 50000 idle cycles, 76 decodes as plain Esc
    send(PS2_EXT, 0);
    idle(TMO);
    send(8'h76, 0);
    check_val("esc_after_tmo", 32'(key_press[KEY_ESC]), 1);
    check_val("esc_after_tmo_unk", 32'(unknown_code), 0);
    send(PS2_BREAK, 0); send(8'h76, 2);

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 50) begin
        k = $urandom_range(0, NK - 1);
        b = tbl[9*k +: 8];
      end else if (r < 62) b = PS2_EXT;
      else if (r < 82)     b = PS2_BREAK;
      else if (r < 86)     b = PS2_PAUSE;
      else                 b = 8'($urandom);
      gap = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 25) : $urandom_range(0, 6);
      send(b, gap, ($urandom_range(0, 39) == 0));
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
